// File: rtl/color_led_matrix_scanner_pkg.sv
// Shared definitions for the colour LED matrix scanner: default line polarities,
// counter width helper and the frame-word field layout.
package color_led_pkg;

  localparam bit DEF_ROW_ACTIVE_LOW = 1'b0;
  localparam bit DEF_COL_ACTIVE_LOW = 1'b1;

  // Width of a counter covering 0..range-1, never narrower than one bit.
  function automatic int cnt_w(input int range);
    return (range <= 1) ? 1 : $clog2(range);
  endfunction

  // Bit offset of LED(r,c) duty code; columns are the outer index.
  function automatic int led_field(input int r, input int c, input int n_rows, input int pwm_bits);
    return (c * n_rows + r) * pwm_bits;
  endfunction

endpackage

// File: rtl/color_led_matrix_scanner_if.sv
// Frame handshake between the frame producer and the scanner.
// valid/ready: a frame transfers on every clock edge where i_frame_valid and o_frame_ready are
// both 1; while ready is 0 the producer must keep valid and data stable until the transfer.
interface color_led_matrix_scanner_if #(parameter int DATA_W = 48);
  logic [DATA_W-1:0] i_frame_data;
  logic              i_frame_valid;
  logic              o_frame_ready;

  modport master (output i_frame_data, output i_frame_valid, input o_frame_ready);
  modport slave  (input i_frame_data, input i_frame_valid, output o_frame_ready);
endinterface

// File: rtl/color_led_matrix_scanner_scan_timer.sv
// Row/slot/PWM counters for the matrix scan, plus the blanking flag and
// frame-boundary / frame-start strobes decoded from the current counter state.
module color_led_scan_timer
  import color_led_pkg::*;
#(
  parameter int N_ROWS       = 4,
  parameter int ROW_PERIOD   = 1040,
  parameter int BLANK_CYCLES = 16,
  parameter int PWM_BITS     = 4,
  localparam int RW = cnt_w(N_ROWS),
  localparam int SW = cnt_w(ROW_PERIOD)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                enable,
  output logic [RW-1:0]       row_cnt,
  output logic [SW-1:0]       slot_cnt,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                blank,
  output logic                boundary,
  output logic                frame_start
);

  localparam logic [RW-1:0] ROW_LAST  = RW'(N_ROWS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(ROW_PERIOD - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);

  logic slot_wrap;
  logic row_wrap;

  assign slot_wrap   = (slot_cnt == SLOT_LAST);
  assign row_wrap    = (row_cnt == ROW_LAST);
  assign blank       = (slot_cnt < BLANK_END);
  assign boundary    = enable && slot_wrap && row_wrap;
  assign frame_start = enable && (slot_cnt == '0) && (row_cnt == '0);

  // Disabled scan parks at row 0 slot 0 so re-enable starts a fresh frame.
  always_ff @(posedge aclk) begin
    if (!aresetn || !enable) begin
      row_cnt  <= '0;
      slot_cnt <= '0;
      pwm_cnt  <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      pwm_cnt  <= '0;
      row_cnt  <= row_wrap ? '0 : row_cnt + RW'(1);
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
      if (!blank) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

endmodule

// File: rtl/color_led_matrix_scanner.sv
// Multiplexed RGB LED matrix driver: double-buffered frame store, per-LED PWM
// compare and registered row/column outputs with configurable polarity.
module color_led_matrix_scanner
  import color_led_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 3,
  parameter int PWM_BITS       = 4,
  parameter int ROW_PERIOD     = 1040,
  parameter int BLANK_CYCLES   = 16,
  parameter bit ROW_ACTIVE_LOW = DEF_ROW_ACTIVE_LOW,
  parameter bit COL_ACTIVE_LOW = DEF_COL_ACTIVE_LOW
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       i_enable,
  color_led_matrix_scanner_if.slave  frame,
  output logic                       o_frame_start,
  output logic [N_ROWS-1:0]          o_row,
  output logic [N_COLS-1:0]          o_col
);

  localparam int DATA_W = N_ROWS * N_COLS * PWM_BITS;
  localparam int RW     = cnt_w(N_ROWS);
  localparam int SW     = cnt_w(ROW_PERIOD);
  localparam logic [N_ROWS-1:0] ROW_OFF = ROW_ACTIVE_LOW ? '1 : '0;
  localparam logic [N_COLS-1:0] COL_OFF = COL_ACTIVE_LOW ? '1 : '0;

  logic [RW-1:0]       row_cnt;
  logic [SW-1:0]       slot_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blank;
  logic                boundary;
  logic                frame_start;

  logic [DATA_W-1:0]   active_buf;
  logic [DATA_W-1:0]   shadow_buf;
  logic                pending;
  logic                accept;
  logic                promote;
  logic                scan_on;
  logic [N_ROWS-1:0]   row_on;
  logic [N_COLS-1:0]   col_on;

  color_led_scan_timer #(
    .N_ROWS      (N_ROWS),
    .ROW_PERIOD  (ROW_PERIOD),
    .BLANK_CYCLES(BLANK_CYCLES),
    .PWM_BITS    (PWM_BITS)
  ) u_timer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable     (i_enable),
    .row_cnt    (row_cnt),
    .slot_cnt   (slot_cnt),
    .pwm_cnt    (pwm_cnt),
    .blank      (blank),
    .boundary   (boundary),
    .frame_start(frame_start)
  );

  assign frame.o_frame_ready = ~pending;
  assign accept  = frame.i_frame_valid && !pending;
  // Swap only with a frame that was already pending; while disabled there is no frame to tear.
  assign promote = pending && (boundary || !i_enable);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      active_buf <= '0;
      shadow_buf <= '0;
      pending    <= 1'b0;
    end else begin
      if (accept) begin
        shadow_buf <= frame.i_frame_data;
        pending    <= 1'b1;
      end
      if (promote) begin
        active_buf <= shadow_buf;
        pending    <= 1'b0;
      end
    end
  end

  assign scan_on = i_enable && !blank;
  assign row_on  = scan_on ? (N_ROWS'(1) << row_cnt) : '0;

  always_comb begin
    col_on = '0;
    for (int c = 0; c < N_COLS; c++) begin
      col_on[c] = scan_on &&
                  (pwm_cnt < active_buf[led_field(int'(row_cnt), c, N_ROWS, PWM_BITS) +: PWM_BITS]);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      o_row         <= ROW_OFF;
      o_col         <= COL_OFF;
      o_frame_start <= 1'b0;
    end else begin
      o_row         <= row_on ^ ROW_OFF;
      o_col         <= col_on ^ COL_OFF;
      o_frame_start <= frame_start;
    end
  end

endmodule

// File: tb/tb_color_led_matrix_scanner.sv
// Directed bench for color_led_matrix_scanner with default parameters (4x3, 4-bit PWM,
// 1040-cycle rows, 16 blank cycles, rows active-high, columns active-low).
module tb_color_led_matrix_scanner;

  localparam int RP    = 1040;
  localparam int BL    = 16;
  localparam int FRAME = 4 * RP;

  logic       clk;
  logic       aresetn;
  logic       enable;
  logic       frame_start;
  logic [3:0] row;
  logic [2:0] col;

  color_led_matrix_scanner_if #(.DATA_W(48)) frame_if ();

  color_led_matrix_scanner dut (
    .aclk         (clk),
    .aresetn      (aresetn),
    .i_enable     (enable),
    .frame        (frame_if),
    .o_frame_start(frame_start),
    .o_row        (row),
    .o_col        (col)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int g;
  int bad;
  int first_g;
  logic [7:0] first_got;
  logic [7:0] first_exp;
  int on_cnt[4][3];
  logic [3:0] cur_duty[4][3];
  logic [3:0] next_duty[4][3];
  logic [3:0] pend_duty[4][3];

  function automatic logic [47:0] pack_next();
    logic [47:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        v[(c * 4 + r) * 4 +: 4] = next_duty[r][c];
    return v;
  endfunction

  task automatic fill_next(input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        next_duty[r][c] = 4'(v);
  endtask

  task automatic reset_stats();
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        on_cnt[r][c] = 0;
  endtask

  // Walk n display cycles comparing against the reference scan of cur_duty.
  task automatic scan(input int n);
    int slot;
    int r;
    int pwm;
    logic [3:0] er;
    logic [2:0] ec;
    logic efs;
    for (int i = 0; i < n; i++) begin
      slot = g % RP;
      r    = g / RP;
      efs  = (g == 0);
      if (slot < BL) begin
        er = 4'b0000;
        ec = 3'b111;
      end else begin
        er  = 4'b0001 << r;
        pwm = (slot - BL) % 16;
        for (int c = 0; c < 3; c++) begin
          ec[c] = !(pwm < int'(cur_duty[r][c]));
          if (col[c] === 1'b0) on_cnt[r][c]++;
        end
      end
      if ({row, col, frame_start} !== {er, ec, efs}) begin
        if (bad == 0) begin
          first_g   = g;
          first_got = {row, col, frame_start};
          first_exp = {er, ec, efs};
        end
        bad++;
      end
      @(negedge clk);
      g = (g + 1) % FRAME;
    end
  endtask

  task automatic check_frame(input string tag, input bit counts);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s scan: %0d bad cycles, first g=%0d got row/col/fs=%b want %b",
               tag, bad, first_g, first_got, first_exp);
    end
    if (counts) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 3; c++) begin
          checks++;
          if (on_cnt[r][c] !== int'(cur_duty[r][c]) * 64) begin
            errors++;
            $display("FAIL %s on_count LED(%0d,%0d): got %0d want %0d",
                     tag, r, c, on_cnt[r][c], int'(cur_duty[r][c]) * 64);
          end
        end
    end
  endtask

  task automatic check_ready(input string tag, input logic want);
    checks++;
    if (frame_if.o_frame_ready !== want) begin
      errors++;
      $display("FAIL %s ready: got %b want %b", tag, frame_if.o_frame_ready, want);
    end
  endtask

  task automatic wait_frame_start(input string tag, input int max);
    bit seen;
    seen = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s frame_start: got none within %0d cycles want pulse", tag, max);
    end
    g = 0;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({row, col, frame_start} !== {4'b0000, 3'b111, 1'b0}) begin
      errors++;
      $display("FAIL %s idle outputs: got row=%b col=%b fs=%b want row=0000 col=111 fs=0",
               tag, row, col, frame_start);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    enable  = 1'b0;
    frame_if.i_frame_valid = 1'b0;
    frame_if.i_frame_data  = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_ready("reset", 1'b1);
    aresetn = 1'b1;
    @(negedge clk);
    check_idle("after_reset_disabled");
  endtask

  // Frame offered while disabled is promoted on the very next cycle.
  task automatic test_load_disabled();
    fill_next(8);
    frame_if.i_frame_data  = pack_next();
    frame_if.i_frame_valid = 1'b1;
    check_ready("load_disabled_pre", 1'b1);
    @(negedge clk);
    frame_if.i_frame_valid = 1'b0;
    check_ready("load_disabled_pending", 1'b0);
    @(negedge clk);
    check_ready("load_disabled_promoted", 1'b1);
    check_idle("load_disabled");
    pend_duty = next_duty;
    cur_duty  = next_duty;
  endtask

  task automatic test_duty();
    enable = 1'b1;
    wait_frame_start("duty", 4);
    reset_stats();
    scan(FRAME);
    check_frame("duty8", 1);
    checks++;
    if (on_cnt[1][2] !== 512) begin
      errors++;
      $display("FAIL duty8 LED(1,2): got %0d want 512", on_cnt[1][2]);
    end
  endtask

  task automatic test_double_buffer();
    reset_stats();
    scan(50);
    fill_next(8);
    next_duty[2][1] = 4'd0;
    next_duty[2][0] = 4'd15;
    next_duty[0][2] = 4'd1;
    next_duty[3][1] = 4'd4;
    frame_if.i_frame_data  = pack_next();
    frame_if.i_frame_valid = 1'b1;
    check_ready("dbuf_offer", 1'b1);
    scan(1);
    check_ready("dbuf_accepted", 1'b0);
    pend_duty = next_duty;
    fill_next(15);
    frame_if.i_frame_data = pack_next();
    scan(100);
    frame_if.i_frame_valid = 1'b0;
    scan(FRAME - 2 - g);
    check_ready("dbuf_before_boundary", 1'b0);
    scan(1);
    check_ready("dbuf_after_boundary", 1'b1);
    scan(1);
    check_frame("dbuf_holds_old", 1);
    cur_duty = pend_duty;
  endtask

  task automatic test_extremes();
    reset_stats();
    scan(FRAME);
    check_frame("extremes", 1);
    checks++;
    if (on_cnt[2][1] !== 0) begin
      errors++;
      $display("FAIL extremes LED(2,1) duty0: got %0d want 0", on_cnt[2][1]);
    end
    checks++;
    if (on_cnt[2][0] !== 960) begin
      errors++;
      $display("FAIL extremes LED(2,0) duty15: got %0d want 960", on_cnt[2][0]);
    end
  endtask

  task automatic test_boundary_collision();
    reset_stats();
    scan(FRAME - 2);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        next_duty[r][c] = 4'(r * 3 + c + 1);
    frame_if.i_frame_data  = pack_next();
    frame_if.i_frame_valid = 1'b1;
    check_ready("collide_offer", 1'b1);
    scan(1);
    frame_if.i_frame_valid = 1'b0;
    check_ready("collide_accepted", 1'b0);
    pend_duty = next_duty;
    scan(1);
    check_frame("collide_frame", 1);
    reset_stats();
    scan(FRAME - 2);
    check_ready("collide_still_pending", 1'b0);
    scan(1);
    check_ready("collide_promoted", 1'b1);
    scan(1);
    check_frame("collide_old_repeats", 1);
    cur_duty = pend_duty;
  endtask

  task automatic test_disable();
    int idle_bad;
    reset_stats();
    scan(2 * RP + 500);
    enable = 1'b0;
    scan(1);
    check_frame("pre_disable", 0);
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 3; c++)
            next_duty[r][c] = 4'(15 - (r * 3 + c));
        frame_if.i_frame_data  = pack_next();
        frame_if.i_frame_valid = 1'b1;
      end
      if (i == 1) begin
        frame_if.i_frame_valid = 1'b0;
        check_ready("disabled_pending", 1'b0);
      end
      if (i == 3) check_ready("disabled_promoted", 1'b1);
      if ({row, col, frame_start} !== {4'b0000, 3'b111, 1'b0}) idle_bad++;
      @(negedge clk);
    end
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("FAIL disabled_outputs: got %0d active cycles want 0", idle_bad);
    end
    cur_duty = next_duty;
    enable = 1'b1;
    wait_frame_start("reenable", 2);
    reset_stats();
    scan(FRAME);
    check_frame("reenable", 1);
  endtask

  task automatic test_reset_pending();
    reset_stats();
    scan(100);
    fill_next(6);
    frame_if.i_frame_data  = pack_next();
    frame_if.i_frame_valid = 1'b1;
    scan(1);
    frame_if.i_frame_valid = 1'b0;
    check_ready("rst_pending", 1'b0);
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("mid_frame_reset");
    check_ready("mid_frame_reset", 1'b1);
    aresetn = 1'b1;
    wait_frame_start("after_reset", 3);
    fill_next(0);
    cur_duty = next_duty;
    reset_stats();
    scan(FRAME);
    check_frame("reset_discards", 1);
    check_ready("reset_discards", 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    g      = 0;
    bad    = 0;
    test_reset();
    test_load_disabled();
    test_duty();
    test_double_buffer();
    test_extremes();
    test_boundary_collision();
    test_disable();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
